// File: rtl/cc_mux_pkg.sv
// Shared definitions for the 10-way mux round-robin arbiter: FSM state encoding
// and the width of the mux select bus.
package cc_mux_pkg;

    localparam int SELECT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/cc_rr_priority_picker.sv
// Combinational round-robin picker: the first set request at or after (ptr+1),
// wrapping mod NUMBER_REQUESTERS, wins.
module cc_rr_priority_picker
    import cc_mux_pkg::*;
#(
    parameter int NUMBER_REQUESTERS = 10
) (
    input  logic [NUMBER_REQUESTERS-1:0] request_i,
    input  logic [SELECT_WIDTH-1:0]      ptr_i,
    output logic [SELECT_WIDTH-1:0]      winner_o,
    output logic                         any_req_o
);

    localparam int SUM_W = SELECT_WIDTH + 1;

    logic [2*NUMBER_REQUESTERS-1:0] doubled;
    logic [NUMBER_REQUESTERS-1:0]   rotated;
    logic [SUM_W-1:0]               shift_amt;
    logic [SUM_W-1:0]               offset;
    logic [SUM_W-1:0]               sum;

    // Rotating the doubled vector by ptr+1 puts requester (ptr+1) at bit 0.
    assign shift_amt = {1'b0, ptr_i} + SUM_W'(1);
    assign doubled   = {request_i, request_i};
    assign rotated   = NUMBER_REQUESTERS'(doubled >> shift_amt);

    always_comb begin
        offset = '0;
        for (int j = NUMBER_REQUESTERS - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                offset = SUM_W'(j);
            end
        end
    end

    always_comb begin
        sum = offset + shift_amt;
        if (sum >= SUM_W'(NUMBER_REQUESTERS)) begin
            sum = sum - SUM_W'(NUMBER_REQUESTERS);
        end
    end

    assign winner_o  = sum[SELECT_WIDTH-1:0];
    assign any_req_o = |request_i;

endmodule

// File: rtl/cc_mux_rr_arbiter.sv
// Round-robin burst arbiter driving the select of a 10-input data mux, with a
// one-hot grant, valid and last-beat indication.
module cc_mux_rr_arbiter
    import cc_mux_pkg::*;
#(
    parameter int NUMBER_REQUESTERS = 10,
    parameter int BURST_LEN         = 4,
    parameter int COUNTER_WIDTH     = 4
) (
    input  logic                         CC_MUX_RR_ARBITER_CLOCK_50,
    input  logic                         CC_MUX_RR_ARBITER_RESET_InHigh,
    input  logic [NUMBER_REQUESTERS-1:0] CC_MUX_RR_ARBITER_request_InBUS,
    input  logic                         CC_MUX_RR_ARBITER_enable_In,
    output logic [SELECT_WIDTH-1:0]      CC_MUX_RR_ARBITER_select_OutBUS,
    output logic [NUMBER_REQUESTERS-1:0] CC_MUX_RR_ARBITER_grant_OutBUS,
    output logic                         CC_MUX_RR_ARBITER_valid_Out,
    output logic                         CC_MUX_RR_ARBITER_last_Out
);

    localparam logic [COUNTER_WIDTH-1:0]     BEAT_LAST = COUNTER_WIDTH'(BURST_LEN - 1);
    localparam logic [SELECT_WIDTH-1:0]      PTR_RESET = SELECT_WIDTH'(NUMBER_REQUESTERS - 1);
    localparam logic [NUMBER_REQUESTERS-1:0] GRANT_ONE = NUMBER_REQUESTERS'(1);

    arb_state_e                   state_q, state_d;
    logic [SELECT_WIDTH-1:0]      select_q, select_d;
    logic [NUMBER_REQUESTERS-1:0] grant_q, grant_d;
    logic [COUNTER_WIDTH-1:0]     beat_q, beat_d;
    logic [SELECT_WIDTH-1:0]      ptr_q, ptr_d;

    logic [SELECT_WIDTH-1:0]      pick_ptr;
    logic [SELECT_WIDTH-1:0]      winner;
    logic                         any_req;
    logic                         owner_req;
    logic                         release_now;

    // On a release the current owner becomes the new pointer in the same edge,
    // so the picker must already see it to hand over without a bubble.
    assign pick_ptr = (state_q == ST_GRANT) ? select_q : ptr_q;

    cc_rr_priority_picker #(
        .NUMBER_REQUESTERS(NUMBER_REQUESTERS)
    ) u_picker (
        .request_i (CC_MUX_RR_ARBITER_request_InBUS),
        .ptr_i     (pick_ptr),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    assign owner_req   = |(CC_MUX_RR_ARBITER_request_InBUS & grant_q);
    assign release_now = (state_q == ST_GRANT) && ((beat_q == BEAT_LAST) || !owner_req);

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        ptr_d    = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (CC_MUX_RR_ARBITER_enable_In && any_req) begin
                    state_d  = ST_GRANT;
                    select_d = winner;
                    grant_d  = GRANT_ONE << winner;
                    beat_d   = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    ptr_d = select_q;
                    if (CC_MUX_RR_ARBITER_enable_In && any_req) begin
                        select_d = winner;
                        grant_d  = GRANT_ONE << winner;
                        beat_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        beat_d  = '0;
                    end
                end else begin
                    beat_d = beat_q + COUNTER_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CC_MUX_RR_ARBITER_CLOCK_50 or posedge CC_MUX_RR_ARBITER_RESET_InHigh) begin
        if (CC_MUX_RR_ARBITER_RESET_InHigh) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
            ptr_q    <= PTR_RESET;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            ptr_q    <= ptr_d;
        end
    end

    assign CC_MUX_RR_ARBITER_select_OutBUS = select_q;
    assign CC_MUX_RR_ARBITER_grant_OutBUS  = grant_q;
    assign CC_MUX_RR_ARBITER_valid_Out     = (state_q == ST_GRANT);
    assign CC_MUX_RR_ARBITER_last_Out      = (state_q == ST_GRANT) && (beat_q == BEAT_LAST);

endmodule
